// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_sram_slave_pkg                                            |
// | Purpose  : Shared response codes, ID width and FSM state encodings for   |
// |            the single-beat AXI SRAM slave.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package axi_sram_slave_pkg;

  localparam int         ID_W      = 4;
  localparam int         CNT_W     = 4;      // wide enough for READ_LAT up to 15
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_sram_slave_sram_word_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_word_array                                               |
// | Purpose  : 32-bit word storage, one combinational read port and one      |
// |            synchronous byte-masked write port. Contents are not reset.   |
// | Ports    : clk                        - write clock                      |
// |            we / waddr / wdata / wstrb - write port, wstrb[i] -> byte i   |
// |            raddr / rdata              - combinational read port          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_word_array #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read is combinational; a sample taken in the same cycle as a write
  // to that word sees the pre-write value.
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_sram_slave                                                |
// | Purpose  : Single-beat AXI slave in front of a word SRAM. Independent    |
// |            read and write FSMs, one outstanding transaction each.        |
// | Ports    : clk, reset (sync, active-high)                                |
// |            AR: arid araddr arvalid arready                               |
// |            R : rid rdata rresp rlast rvalid rready                       |
// |            AW: awid awaddr awvalid awready                               |
// |            W : wdata wstrb wvalid wready                                 |
// |            B : bid bresp bvalid bready                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int READ_LAT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int IDX_W = ADDR_BITS - 2;

  // ---------------- read channel ----------------
  rd_state_t        rd_state, rd_next;
  logic [CNT_W-1:0] rd_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [ID_W-1:0]  rid_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem_rdata;
  logic             ar_fire;

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = ~reset;
        if (arvalid && !reset) rd_next = R_WAIT;
      end
      R_WAIT: if (rd_cnt == '0) rd_next = R_RESP;
      R_RESP: begin
        rvalid = ~reset;
        if (rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign ar_fire = arvalid & arready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_idx   <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_fire) begin
        rid_q  <= arid;
        rd_idx <= araddr[ADDR_BITS-1:2];
        rd_cnt <= CNT_W'(READ_LAT - 1);
      end else if (rd_state == R_WAIT) begin
        if (rd_cnt == '0) rdata_q <= mem_rdata;
        else              rd_cnt  <= rd_cnt - 1'b1;
      end
    end
  end

  assign rid   = rid_q;
  assign rdata = rdata_q;
  assign rresp = RESP_OKAY;
  assign rlast = rvalid;

  // ---------------- write channel ----------------
  wr_state_t        wr_state, wr_next;
  logic             aw_cap, w_cap;
  logic [IDX_W-1:0] aw_idx;
  logic [ID_W-1:0]  bid_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_fire, w_fire, commit;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    commit  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = ~reset & ~aw_cap;
        wready  = ~reset & ~w_cap;
        // Commit as soon as both halves are present, counting a half that
        // is being handed over in this very cycle.
        commit  = ~reset & (aw_cap | (awvalid & ~aw_cap))
                         & (w_cap  | (wvalid  & ~w_cap));
        if (commit) wr_next = W_RESP;
      end
      W_RESP: begin
        bvalid = ~reset;
        if (bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  assign mem_waddr = aw_cap ? aw_idx  : awaddr[ADDR_BITS-1:2];
  assign mem_wdata = w_cap  ? wdata_q : wdata;
  assign mem_wstrb = w_cap  ? wstrb_q : wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      aw_cap   <= 1'b0;
      w_cap    <= 1'b0;
      aw_idx   <= '0;
      bid_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_fire) begin
        aw_cap <= 1'b1;
        aw_idx <= awaddr[ADDR_BITS-1:2];
        bid_q  <= awid;
      end
      if (w_fire) begin
        w_cap   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (wr_state == W_RESP && bready) begin
        aw_cap <= 1'b0;
        w_cap  <= 1'b0;
      end
    end
  end

  assign bid   = bid_q;
  assign bresp = RESP_OKAY;

  // ---------------- storage ----------------
  sram_word_array #(.IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (commit),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wstrb (mem_wstrb),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // Upper address bits alias and byte-offset bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:ADDR_BITS], araddr[1:0],
                              awaddr[31:ADDR_BITS], awaddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_sram_slave                                             |
// | Purpose  : Scoreboard bench for axi_sram_slave: drivers push expected    |
// |            responses, a monitor pops and compares them.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi_sram_slave;

  localparam int ADDR_BITS = 16;
  localparam int READ_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_sram_slave #(.ADDR_BITS(ADDR_BITS), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [3:0] id; logic [31:0] data; int t; } rexp_t;
  typedef struct { logic [3:0] id; int t; } bexp_t;
  rexp_t rd_q[$];
  bexp_t wr_q[$];

  logic [31:0] model [int];
  logic [31:0] written[$];
  bit stall_r = 1'b0, stall_b = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_BITS-1:2]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  bit rv_act = 1'b0, bv_act = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      check("valids_in_reset", 64'({rvalid, bvalid}), 64'(0));
      check("readies_in_reset", 64'({arready, awready, wready}), 64'(0));
      rv_act = 1'b0;
      bv_act = 1'b0;
    end else begin
      if (rvalid) begin
        if (rd_q.size() == 0) flag("unexpected_rvalid");
        else begin
          if (!rv_act) begin
            check("r_latency", 64'(cyc), 64'(rd_q[0].t));
            rv_act = 1'b1;
          end
          check("r_beat", 64'({rid, rdata, rresp, rlast, arready}),
                64'({rd_q[0].id, rd_q[0].data, 2'b00, 1'b1, 1'b0}));
          if (rready) begin
            void'(rd_q.pop_front());
            rv_act = 1'b0;
          end
        end
      end
      if (bvalid) begin
        if (wr_q.size() == 0) flag("unexpected_bvalid");
        else begin
          if (!bv_act) begin
            check("b_latency", 64'(cyc), 64'(wr_q[0].t));
            bv_act = 1'b1;
          end
          check("b_beat", 64'({bid, bresp, awready, wready}),
                64'({wr_q[0].id, 2'b00, 1'b0, 1'b0}));
          if (bready) begin
            void'(wr_q.pop_front());
            bv_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- response-ready driver ----------------
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rready = !stall_r && ($urandom_range(0, 3) != 0);
      bready = !stall_b && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- request drivers ----------------
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, output int hs);
    int n = 0;
    @(posedge clk); #1;
    arid = id; araddr = addr; arvalid = 1'b1;
    hs = -1;
    while (hs < 0 && n < 100) begin
      @(negedge clk);
      if (arready) hs = cyc + 1;
      n++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (hs < 0) flag("ar_timeout");
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int dly, output int hs);
    int n = 0;
    repeat (dly + 1) @(posedge clk);
    #1;
    awid = id; awaddr = addr; awvalid = 1'b1;
    hs = -1;
    while (hs < 0 && n < 100) begin
      @(negedge clk);
      if (awready) hs = cyc + 1;
      n++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    if (hs < 0) flag("aw_timeout");
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output int hs);
    int n = 0;
    repeat (dly + 1) @(posedge clk);
    #1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    hs = -1;
    while (hs < 0 && n < 100) begin
      @(negedge clk);
      if (wready) hs = cyc + 1;
      n++;
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    if (hs < 0) flag("w_timeout");
  endtask

  // mode 0: AW and W together, 1: AW first by gap, 2: W first by gap
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int mode, input int gap);
    int ha, hw, da, dw, i;
    logic [31:0] w;
    da = (mode == 2) ? gap : 0;
    dw = (mode == 1) ? gap : 0;
    fork
      send_aw(id, addr, da, ha);
      send_w(data, strb, dw, hw);
    join
    i = widx(addr);
    w = model.exists(i) ? model[i] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    model[i] = w;
    wr_q.push_back('{id: id, t: (ha > hw) ? ha : hw});
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr);
    int hs;
    send_ar(id, addr, hs);
    rd_q.push_back('{id: id, data: model[widx(addr)], t: hs + READ_LAT});
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag("drain_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("readies_after_reset", 64'({arready, awready, wready}), 64'(3'b111));
    check("regs_after_reset", 64'({rid, bid, rdata, rvalid, bvalid}), 64'(0));

    // write then read
    do_write(4'h5, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0); drain();
    do_read(4'h3, 32'h100); drain();
    // W accepted 3 cycles ahead of AW
    do_write(4'h9, 32'h8, 32'h11223344, 4'hF, 2, 3); drain();
    do_read(4'h1, 32'h8); drain();
    // AW ahead of W
    do_write(4'hA, 32'h30, 32'h0BADF00D, 4'hF, 1, 2); drain();
    do_read(4'h2, 32'h30); drain();
    // byte strobe, then an all-zero strobe
    do_write(4'h4, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0); drain();
    do_write(4'h6, 32'h20, 32'h00AB0000, 4'h4, 0, 0); drain();
    do_read(4'hC, 32'h20); drain();
    do_write(4'h7, 32'h20, 32'h12345678, 4'h0, 0, 0); drain();
    do_read(4'hD, 32'h20); drain();
    // aliasing through upper and low-order address bits
    do_read(4'hE, 32'h0001_0023); drain();
    written.push_back(32'h100); written.push_back(32'h8);
    written.push_back(32'h30);  written.push_back(32'h20);

    // backpressure on both response channels
    stall_r = 1'b1;
    do_read(4'hB, 32'h100);
    repeat (READ_LAT + 6) @(negedge clk);
    stall_r = 1'b0;
    drain();
    stall_b = 1'b1;
    do_write(4'h8, 32'h44, 32'h55AA55AA, 4'hF, 0, 0);
    repeat (6) @(negedge clk);
    stall_b = 1'b0;
    drain();
    written.push_back(32'h44);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      if ($urandom_range(0, 1) == 1) begin
        a = written[$urandom_range(0, written.size() - 1)];
        a = a ^ ($urandom << ADDR_BITS) ^ ($urandom & 32'h3);
        do_read(4'($urandom), a);
      end else begin
        a = $urandom;
        s = model.exists(widx(a)) ? 4'($urandom) : 4'hF;
        written.push_back(a);
        do_write(4'($urandom), a, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      drain();
    end

    // reset with a write parked in its response state and a read in flight
    stall_b = 1'b1;
    stall_r = 1'b1;
    do_write(4'h2, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    repeat (2) @(negedge clk);
    do_read(4'h7, 32'h100);
    reset = 1'b1;
    rd_q.delete();
    wr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    stall_b = 1'b0;
    stall_r = 1'b0;
    @(negedge clk);
    check("readies_after_mid_reset", 64'({arready, awready, wready}), 64'(3'b111));
    check("regs_after_mid_reset", 64'({rid, bid, rdata, rvalid, bvalid}), 64'(0));
    repeat (READ_LAT + 5) @(negedge clk);
    do_read(4'h3, 32'h40);  drain();
    do_read(4'h4, 32'h100); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
